// File: rtl/arb_rr_4.sv
// Four-requester round-robin arbiter with a per-owner quantum.
// Registered one-hot grant; the owner is preempted after QUANTUM cycles when another requester waits.
module arb_rr_4 #(
    parameter int unsigned QUANTUM = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       new_gnt
);

    localparam int unsigned CW = (QUANTUM > 2) ? $clog2(QUANTUM) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(QUANTUM - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t        r_state;
    logic [1:0]    r_ptr;
    logic [CW-1:0] r_hold;
    logic [3:0]    r_gnt;
    logic [1:0]    r_gnt_id;
    logic          r_busy;
    logic          r_new_gnt;

    logic       w_any_vld;
    logic [1:0] w_any_idx;
    logic       w_oth_vld;
    logic [1:0] w_oth_idx;
    logic       w_do_grant;
    logic [1:0] w_grant_idx;
    logic       w_go_idle;

    // First requester after ptr; the "others" search skips ptr itself, which is the owner in S_OWN.
    always_comb begin
        w_any_vld = 1'b0;
        w_any_idx = r_ptr;
        w_oth_vld = 1'b0;
        w_oth_idx = r_ptr;
        for (int k = 4; k >= 1; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_any_vld = 1'b1;
                w_any_idx = r_ptr + 2'(k);
            end
        end
        for (int k = 3; k >= 1; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_oth_vld = 1'b1;
                w_oth_idx = r_ptr + 2'(k);
            end
        end
    end

    // Rearbitration decision for the coming edge.
    always_comb begin
        w_do_grant  = 1'b0;
        w_grant_idx = w_any_idx;
        w_go_idle   = 1'b0;
        if (en) begin
            case (r_state)
                S_IDLE: w_do_grant = w_any_vld;
                S_OWN: begin
                    if (!req[r_gnt_id] || (r_hold == HOLD_MAX)) begin
                        if (w_oth_vld) begin
                            w_do_grant  = 1'b1;
                            w_grant_idx = w_oth_idx;
                        end else if (!req[r_gnt_id]) begin
                            w_go_idle = 1'b1;
                        end
                    end
                end
                default: w_go_idle = 1'b1;
            endcase
        end
    end

    // Arbiter FSM and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= 2'b11;
            r_hold    <= '0;
            r_gnt     <= 4'b0000;
            r_gnt_id  <= 2'b00;
            r_busy    <= 1'b0;
            r_new_gnt <= 1'b0;
        end else begin
            r_new_gnt <= 1'b0;
            if (!en || w_go_idle) begin
                r_state <= S_IDLE;
                r_gnt   <= 4'b0000;
                r_busy  <= 1'b0;
                r_hold  <= '0;
            end else if (w_do_grant) begin
                r_state   <= S_OWN;
                r_ptr     <= w_grant_idx;
                r_gnt_id  <= w_grant_idx;
                r_gnt     <= 4'b0001 << w_grant_idx;
                r_busy    <= 1'b1;
                r_hold    <= '0;
                r_new_gnt <= 1'b1;
            end else if (r_state == S_OWN) begin
                // Lone owner at quantum end keeps the grant with a fresh count.
                if (r_hold == HOLD_MAX) begin
                    r_hold <= '0;
                end else begin
                    r_hold <= r_hold + CW'(1);
                end
            end
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign new_gnt = r_new_gnt;

endmodule

// File: tb/tb_arb_rr_4.sv
// Bench for arb_rr_4: directed scenarios plus random requests against a round-robin reference model.
module tb_arb_rr_4;

    localparam int TQ = 4;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       new_gnt;

    int n_chk;
    int n_err;

    // Reference model state: owner (-1 = none), last owner, cycles held since grant.
    int m_owner;
    int m_ptr;
    int m_run;
    bit m_new;

    arb_rr_4 #(.QUANTUM(TQ)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .new_gnt (new_gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (p + k) % 4;
            if (idx != excl && r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_run   = 0;
        m_new   = 1'b0;
    endtask

    task automatic model_grant(input int idx);
        m_owner = idx;
        m_ptr   = idx;
        m_run   = 0;
        m_new   = 1'b1;
    endtask

    task automatic model_step();
        int n;
        m_new = 1'b0;
        if (!en) begin
            m_owner = -1;
        end else if (m_owner < 0) begin
            if (req != 4'b0000) model_grant(pick(req, m_ptr, -1));
        end else if (!req[m_owner]) begin
            n = pick(req, m_ptr, m_owner);
            if (n >= 0) model_grant(n);
            else m_owner = -1;
        end else if (m_run == TQ - 1) begin
            n = pick(req, m_ptr, m_owner);
            if (n >= 0) model_grant(n);
            else m_run = 0;
        end else begin
            m_run++;
        end
    endtask

    task automatic compare();
        logic [3:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("new_gnt", 32'(new_gnt), 32'(m_new));
        if (m_owner >= 0) chk("gnt_id", 32'(gnt_id), 32'(m_owner));
        chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
        compare();
    endtask

    task automatic run(input logic e, input logic [3:0] r, input int cycles);
        en  = e;
        req = r;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        clk     = 1'b0;
        reset_n = 1'b0;
        en      = 1'b0;
        req     = 4'b0000;
        model_reset();

        // Reset state, then release with requests already present.
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_new_gnt", 32'(new_gnt), 32'd0);
        reset_n = 1'b1;
        en      = 1'b1;
        req     = 4'b1111;
        #1;
        chk("no_grant_before_edge", 32'(gnt), 32'd0);

        // Full rotation, four cycles per owner.
        for (int i = 0; i < 17; i++) tick();

        // Lone requester keeps the grant across quantum boundaries.
        run(1'b0, 4'b0100, 1);
        run(1'b1, 4'b0100, 10);

        // Owner 1 releases with requester 3 waiting: no idle gap.
        run(1'b1, 4'b0010, 3);
        run(1'b1, 4'b1010, 2);
        run(1'b1, 4'b1000, 2);

        // Owner 2, all drop, then 0101 searched from ptr=2.
        run(1'b1, 4'b0100, 2);
        run(1'b1, 4'b0000, 2);
        run(1'b1, 4'b0101, 3);

        // Owner 3, one cycle of en=0, then 1001.
        run(1'b1, 4'b1000, 3);
        run(1'b0, 4'b1000, 1);
        run(1'b1, 4'b1001, 3);

        // Owner 1 with reset pulsed mid-cycle.
        run(1'b1, 4'b0010, 3);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_gnt", 32'(gnt), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        req     = 4'b0010;
        tick();
        tick();

        // Random requests with sticky bits and occasional disable.
        req = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] flip;
            flip = 4'b0000;
            for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 5) == 0);
            req = req ^ flip;
            en  = ($urandom_range(0, 29) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
